// File: rtl/emu_boot_ctrl.sv
// ============================================================================
// Module      : emu_boot_ctrl
// Description : Emulator core boot sequencer: holds core reset, latches the
//               configuration switches, then runs the core with a divided CPU
//               clock enable. The optional watchdog is built when the macro
//               BOOT_WDOG_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module emu_boot_ctrl #(
    parameter int unsigned RESET_CYCLES = 16,
    parameter int unsigned TURBO_DIV    = 2,
    parameter int unsigned NORMAL_DIV   = 4,
    parameter int unsigned WDOG_CYCLES  = 65535
) (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic [7:0] i_cfg_sw,
    input  logic       i_cfg_load,
    input  logic       i_turbo,
    input  logic       i_alive,
    output logic       o_core_reset_n,
    output logic [7:0] o_cfg_sw,
    output logic       o_cpu_ce,
    output logic [1:0] o_state,
    output logic       o_wdog_trip
);

    typedef enum logic [1:0] {
        S_HOLD  = 2'b00,
        S_LATCH = 2'b01,
        S_RUN   = 2'b10
    } state_t;

    localparam logic [15:0] c_HOLD_LAST   = 16'(RESET_CYCLES - 1);
    localparam logic [3:0]  c_TURBO_LAST  = 4'(TURBO_DIV - 1);
    localparam logic [3:0]  c_NORMAL_LAST = 4'(NORMAL_DIV - 1);

    state_t      r_state;
    state_t      w_next_state;
    logic [15:0] r_hold_cnt;
    logic [15:0] w_hold_cnt_nxt;
    logic [3:0]  r_div_cnt;
    logic [3:0]  w_div_cnt_nxt;
    logic [3:0]  w_div_last;
    logic        w_latch_en;
    logic        w_wdog_expire;
    logic [7:0]  r_cfg_sw;
    logic        r_turbo_q;
    logic        r_cpu_ce;
    logic        r_core_reset_n;

    assign w_div_last = r_turbo_q ? c_TURBO_LAST : c_NORMAL_LAST;

    always_comb begin
        w_next_state   = r_state;
        w_hold_cnt_nxt = r_hold_cnt;
        w_div_cnt_nxt  = '0;
        w_latch_en     = 1'b0;
        case (r_state)
            S_HOLD: begin
                if (r_hold_cnt == c_HOLD_LAST) begin
                    w_next_state   = S_LATCH;
                    w_latch_en     = 1'b1;
                    w_hold_cnt_nxt = '0;
                end else begin
                    w_hold_cnt_nxt = r_hold_cnt + 16'd1;
                end
            end
            S_LATCH: begin
                w_next_state = S_RUN;
            end
            S_RUN: begin
                // Watchdog expiry and reload share the same re-reset path
                if (i_cfg_load || w_wdog_expire) begin
                    w_next_state   = S_HOLD;
                    w_hold_cnt_nxt = '0;
                end else if (r_div_cnt != w_div_last) begin
                    w_div_cnt_nxt = r_div_cnt + 4'd1;
                end
            end
            default: begin
                w_next_state   = S_HOLD;
                w_hold_cnt_nxt = '0;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state        <= S_HOLD;
            r_hold_cnt     <= '0;
            r_div_cnt      <= '0;
            r_cfg_sw       <= 8'h00;
            r_turbo_q      <= 1'b0;
            r_cpu_ce       <= 1'b0;
            r_core_reset_n <= 1'b0;
        end else begin
            r_state        <= w_next_state;
            r_hold_cnt     <= w_hold_cnt_nxt;
            r_div_cnt      <= w_div_cnt_nxt;
            // Flags track the next state so they line up with o_state
            r_core_reset_n <= (w_next_state == S_RUN);
            r_cpu_ce       <= (w_next_state == S_RUN) && (w_div_cnt_nxt == w_div_last);
            if (w_latch_en) begin
                r_cfg_sw  <= i_cfg_sw;
                r_turbo_q <= i_turbo;
            end
        end
    end

`ifdef BOOT_WDOG_EN
    localparam logic [19:0] c_WDOG_LAST = 20'(WDOG_CYCLES - 1);

    logic [19:0] r_wdog_cnt;
    logic        r_wdog_trip;

    assign w_wdog_expire = (r_state == S_RUN) && !i_alive && (r_wdog_cnt == c_WDOG_LAST);

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_wdog_cnt  <= '0;
            r_wdog_trip <= 1'b0;
        end else begin
            if ((r_state != S_RUN) || i_alive || w_wdog_expire) begin
                r_wdog_cnt <= '0;
            end else begin
                r_wdog_cnt <= r_wdog_cnt + 20'd1;
            end
            if (w_wdog_expire) begin
                r_wdog_trip <= 1'b1;
            end
        end
    end

    assign o_wdog_trip = r_wdog_trip;
`else
    logic [19:0] w_unused_wdog;

    assign w_unused_wdog = 20'(WDOG_CYCLES) ^ {19'd0, i_alive};
    assign w_wdog_expire = 1'b0;
    assign o_wdog_trip   = 1'b0;
`endif

    assign o_state        = r_state;
    assign o_core_reset_n = r_core_reset_n;
    assign o_cfg_sw       = r_cfg_sw;
    assign o_cpu_ce       = r_cpu_ce;

endmodule

`default_nettype wire

// File: tb/tb_emu_boot_ctrl.sv
// ============================================================================
// Module      : tb_emu_boot_ctrl
// Description : Directed self-checking bench for emu_boot_ctrl.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_emu_boot_ctrl;

    logic       i_clk      = 1'b0;
    logic       i_reset    = 1'b1;
    logic [7:0] i_cfg_sw   = 8'h00;
    logic       i_cfg_load = 1'b0;
    logic       i_turbo    = 1'b0;
    logic       i_alive    = 1'b0;
    logic       o_core_reset_n;
    logic [7:0] o_cfg_sw;
    logic       o_cpu_ce;
    logic [1:0] o_state;
    logic       o_wdog_trip;

    int errors = 0;
    int checks = 0;

    always #5 i_clk = ~i_clk;

    emu_boot_ctrl #(
        .RESET_CYCLES (16),
        .TURBO_DIV    (2),
        .NORMAL_DIV   (4),
        .WDOG_CYCLES  (100)
    ) dut (
        .i_clk          (i_clk),
        .i_reset        (i_reset),
        .i_cfg_sw       (i_cfg_sw),
        .i_cfg_load     (i_cfg_load),
        .i_turbo        (i_turbo),
        .i_alive        (i_alive),
        .o_core_reset_n (o_core_reset_n),
        .o_cfg_sw       (o_cfg_sw),
        .o_cpu_ce       (o_cpu_ce),
        .o_state        (o_state),
        .o_wdog_trip    (o_wdog_trip)
    );

    task automatic step();
        @(posedge i_clk);
        #1;
    endtask

    task automatic test_reset();
        logic [1:0] exp_st;
        logic [7:0] exp_cfg;
        logic       exp_rn;
        i_reset = 1'b1; i_cfg_sw = 8'h83; i_turbo = 1'b1; i_cfg_load = 1'b0; i_alive = 1'b0;
        repeat (3) step();
        checks++; if (o_state !== 2'b00) begin errors++; $display("FAIL reset_state got=%b exp=00", o_state); end
        checks++; if (o_core_reset_n !== 1'b0) begin errors++; $display("FAIL reset_rstn got=%b exp=0", o_core_reset_n); end
        checks++; if (o_cfg_sw !== 8'h00) begin errors++; $display("FAIL reset_cfg got=%h exp=00", o_cfg_sw); end
        checks++; if (o_cpu_ce !== 1'b0) begin errors++; $display("FAIL reset_ce got=%b exp=0", o_cpu_ce); end
        checks++; if (o_wdog_trip !== 1'b0) begin errors++; $display("FAIL reset_trip got=%b exp=0", o_wdog_trip); end
        i_reset = 1'b0;
        for (int k = 0; k <= 16; k++) begin
            step();
            exp_st  = (k < 15) ? 2'b00 : ((k == 15) ? 2'b01 : 2'b10);
            exp_cfg = (k >= 15) ? 8'h83 : 8'h00;
            exp_rn  = (k == 16);
            checks++; if (o_state !== exp_st) begin errors++; $display("FAIL boot_state k=%0d got=%b exp=%b", k, o_state, exp_st); end
            checks++; if (o_cfg_sw !== exp_cfg) begin errors++; $display("FAIL boot_cfg k=%0d got=%h exp=%h", k, o_cfg_sw, exp_cfg); end
            checks++; if (o_core_reset_n !== exp_rn) begin errors++; $display("FAIL boot_rstn k=%0d got=%b exp=%b", k, o_core_reset_n, exp_rn); end
            checks++; if (o_cpu_ce !== 1'b0) begin errors++; $display("FAIL boot_ce k=%0d got=%b exp=0", k, o_cpu_ce); end
        end
    endtask

    task automatic test_ce_turbo();
        logic exp_ce;
        for (int j = 1; j <= 8; j++) begin
            if (j == 4) i_turbo = 1'b0;
            step();
            exp_ce = ((j % 2) == 1);
            checks++; if (o_cpu_ce !== exp_ce) begin errors++; $display("FAIL ce_turbo j=%0d got=%b exp=%b", j, o_cpu_ce, exp_ce); end
        end
    endtask

    task automatic test_relatch();
        logic [1:0] exp_st;
        logic [7:0] exp_cfg;
        i_cfg_sw = 8'h05; i_turbo = 1'b0; i_cfg_load = 1'b1;
        step();
        i_cfg_load = 1'b0;
        checks++; if (o_state !== 2'b00) begin errors++; $display("FAIL load_state got=%b exp=00", o_state); end
        checks++; if (o_core_reset_n !== 1'b0) begin errors++; $display("FAIL load_rstn got=%b exp=0", o_core_reset_n); end
        checks++; if (o_cpu_ce !== 1'b0) begin errors++; $display("FAIL load_ce got=%b exp=0", o_cpu_ce); end
        for (int m = 1; m <= 17; m++) begin
            if (m == 5 || m == 17) i_cfg_load = 1'b1;
            step();
            i_cfg_load = 1'b0;
            exp_st  = (m < 16) ? 2'b00 : ((m == 16) ? 2'b01 : 2'b10);
            exp_cfg = (m >= 16) ? 8'h05 : 8'h83;
            checks++; if (o_state !== exp_st) begin errors++; $display("FAIL relatch_state m=%0d got=%b exp=%b", m, o_state, exp_st); end
            checks++; if (o_cfg_sw !== exp_cfg) begin errors++; $display("FAIL relatch_cfg m=%0d got=%h exp=%h", m, o_cfg_sw, exp_cfg); end
            checks++; if (o_core_reset_n !== (m == 17)) begin errors++; $display("FAIL relatch_rstn m=%0d got=%b exp=%b", m, o_core_reset_n, (m == 17)); end
        end
    endtask

    task automatic test_ce_normal();
        logic exp_ce;
        for (int j = 1; j <= 8; j++) begin
            if (j == 2) i_turbo = 1'b1;
            step();
            exp_ce = ((j % 4) == 3);
            checks++; if (o_cpu_ce !== exp_ce) begin errors++; $display("FAIL ce_normal j=%0d got=%b exp=%b", j, o_cpu_ce, exp_ce); end
        end
        i_turbo = 1'b0;
    endtask

`ifdef BOOT_WDOG_EN
    task automatic test_wdog();
        int bad = 0;
        for (int n = 0; n < 200; n++) begin
            i_alive = ((n % 50) == 0);
            step();
            if (o_state !== 2'b10 || o_wdog_trip !== 1'b0) bad++;
        end
        i_alive = 1'b0;
        checks++; if (bad != 0) begin errors++; $display("FAIL wdog_kicked bad_cycles=%0d exp=0", bad); end
        i_alive = 1'b1; step(); i_alive = 1'b0;
        for (int n = 1; n <= 100; n++) begin
            step();
            if (n == 99) begin
                checks++; if (o_state !== 2'b10) begin errors++; $display("FAIL wdog_pre_state got=%b exp=10", o_state); end
                checks++; if (o_wdog_trip !== 1'b0) begin errors++; $display("FAIL wdog_pre_trip got=%b exp=0", o_wdog_trip); end
            end
        end
        checks++; if (o_state !== 2'b00) begin errors++; $display("FAIL wdog_exp_state got=%b exp=00", o_state); end
        checks++; if (o_wdog_trip !== 1'b1) begin errors++; $display("FAIL wdog_exp_trip got=%b exp=1", o_wdog_trip); end
        checks++; if (o_core_reset_n !== 1'b0) begin errors++; $display("FAIL wdog_exp_rstn got=%b exp=0", o_core_reset_n); end
        repeat (17) step();
        checks++; if (o_state !== 2'b10) begin errors++; $display("FAIL wdog_rerun_state got=%b exp=10", o_state); end
        checks++; if (o_wdog_trip !== 1'b1) begin errors++; $display("FAIL wdog_sticky got=%b exp=1", o_wdog_trip); end
        repeat (99) step();
        checks++; if (o_state !== 2'b10) begin errors++; $display("FAIL simul_pre_state got=%b exp=10", o_state); end
        i_cfg_load = 1'b1; step(); i_cfg_load = 1'b0;
        checks++; if (o_state !== 2'b00) begin errors++; $display("FAIL simul_state got=%b exp=00", o_state); end
        checks++; if (o_wdog_trip !== 1'b1) begin errors++; $display("FAIL simul_trip got=%b exp=1", o_wdog_trip); end
        repeat (15) step();
        checks++; if (o_state !== 2'b00) begin errors++; $display("FAIL simul_hold got=%b exp=00", o_state); end
        step();
        checks++; if (o_state !== 2'b01) begin errors++; $display("FAIL simul_latch got=%b exp=01", o_state); end
    endtask
`else
    task automatic test_wdog_off();
        repeat (150) step();
        checks++; if (o_state !== 2'b10) begin errors++; $display("FAIL nowdog_state got=%b exp=10", o_state); end
        checks++; if (o_wdog_trip !== 1'b0) begin errors++; $display("FAIL nowdog_trip got=%b exp=0", o_wdog_trip); end
    endtask
`endif

    task automatic test_reset_mid();
        logic found = 1'b0;
        for (int n = 0; n < 40 && !found; n++) begin
            if (o_state == 2'b10) found = 1'b1;
            else step();
        end
        checks++; if (!found) begin errors++; $display("FAIL wait_run got=%b exp=10", o_state); end
        i_cfg_sw = 8'h3C; i_cfg_load = 1'b1; step(); i_cfg_load = 1'b0;
        repeat (16) step();
        checks++; if (o_state !== 2'b01) begin errors++; $display("FAIL mid_latch got=%b exp=01", o_state); end
        checks++; if (o_cfg_sw !== 8'h3C) begin errors++; $display("FAIL mid_cfg got=%h exp=3c", o_cfg_sw); end
        i_reset = 1'b1; step();
        checks++; if (o_state !== 2'b00) begin errors++; $display("FAIL abort_state got=%b exp=00", o_state); end
        checks++; if (o_cfg_sw !== 8'h00) begin errors++; $display("FAIL abort_cfg got=%h exp=00", o_cfg_sw); end
        checks++; if (o_core_reset_n !== 1'b0) begin errors++; $display("FAIL abort_rstn got=%b exp=0", o_core_reset_n); end
        checks++; if (o_wdog_trip !== 1'b0) begin errors++; $display("FAIL abort_trip got=%b exp=0", o_wdog_trip); end
        i_reset = 1'b0;
        repeat (15) step();
        checks++; if (o_state !== 2'b00) begin errors++; $display("FAIL rehold_state got=%b exp=00", o_state); end
        step();
        checks++; if (o_state !== 2'b01) begin errors++; $display("FAIL relatch2_state got=%b exp=01", o_state); end
    endtask

    initial begin
        test_reset();
        test_ce_turbo();
        test_relatch();
        test_ce_normal();
`ifdef BOOT_WDOG_EN
        test_wdog();
`else
        test_wdog_off();
`endif
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL global_timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

endmodule

`default_nettype wire

// File: doc/emu_boot_ctrl.md
EMU_BOOT_CTRL -- requirements
Module: emu_boot_ctrl

Interface
REQ-001 SHALL have parameter RESET_CYCLES, default 16: number of cycles core reset is held in HOLD, legal range 2..65535.
REQ-002 SHALL have parameter TURBO_DIV, default 2: CPU clock-enable divide ratio when turbo is selected, legal range 1..15.
REQ-003 SHALL have parameter NORMAL_DIV, default 4: CPU clock-enable divide ratio when turbo is not selected, legal range 1..15.
REQ-004 SHALL have parameter WDOG_CYCLES, default 65535: watchdog timeout in cycles, legal range 2..2^20-1.
REQ-005 SHALL have port i_clk  input  1: the single clock; all logic is rising-edge.
REQ-006 SHALL have port i_reset  input  1: reset; it is synchronous and active-high.
REQ-007 SHALL have port i_cfg_sw  input  8: raw configuration switches feeding the core.
REQ-008 SHALL have port i_cfg_load  input  1: single-cycle request to re-latch switches and re-reset the core.
REQ-009 SHALL have port i_turbo  input  1: turbo select, 1 selects TURBO_DIV.
REQ-010 SHALL have port i_alive  input  1: core heartbeat pulse that kicks the watchdog.
REQ-011 SHALL have port o_core_reset_n  output  1: active-low reset to the core.
REQ-012 SHALL have port o_cfg_sw  output  8: latched switches to the core.
REQ-013 SHALL have port o_cpu_ce  output  1: single-cycle CPU clock enable.
REQ-014 SHALL have port o_state  output  2: current FSM state, 00 HOLD, 01 LATCH, 10 RUN.
REQ-015 SHALL have port o_wdog_trip  output  1: sticky watchdog-expired flag.

Function
REQ-016 SHALL implement FSM HOLD -> LATCH -> RUN, with all outputs registered.
REQ-017 HOLD SHALL keep o_core_reset_n=0, count RESET_CYCLES cycles starting at 0 on entry, and go to LATCH on the edge where count equals RESET_CYCLES-1.
REQ-018 The HOLD->LATCH edge SHALL capture i_cfg_sw into o_cfg_sw and i_turbo into an internal turbo_q; both are otherwise held.
REQ-019 LATCH SHALL last exactly 1 cycle with o_core_reset_n=0, then go to RUN.
REQ-020 In RUN, o_core_reset_n SHALL be 1, so that o_cfg_sw is stable at least 1 cycle before reset release.
REQ-021 The CE divider SHALL clear on RUN entry, count modulo DIV (DIV=TURBO_DIV if turbo_q else NORMAL_DIV), and assert o_cpu_ce for 1 cycle when count equals DIV-1.
REQ-022 With DIV=1, o_cpu_ce SHALL be continuously 1 in RUN.
REQ-023 o_cpu_ce SHALL be 0 in HOLD and LATCH.
REQ-024 i_turbo changes during RUN SHALL have no effect until the next LATCH.
REQ-025 i_cfg_load in RUN SHALL move the FSM to HOLD next cycle, asserting o_core_reset_n=0 and restarting the hold count.
REQ-026 i_cfg_load in HOLD or LATCH SHALL be ignored.
REQ-027 The watchdog SHALL follow the watchdog rules in REQ-031..REQ-032.
REQ-028 Wdog expiry coinciding with i_cfg_load SHALL behave as expiry: HOLD entered, o_wdog_trip set.

Reset
REQ-029 While i_reset=1 at a clock edge, the block SHALL apply: state HOLD, hold count 0, o_core_reset_n=0, o_cfg_sw=8'h00, turbo_q=0, o_cpu_ce=0, o_wdog_trip=0, watchdog count 0.
REQ-030 After the first edge with i_reset=0, o_core_reset_n SHALL rise exactly RESET_CYCLES+1 cycles later; i_reset asserted in any state SHALL abort to the reset values.

Configuration
REQ-031 With macro BOOT_WDOG_EN defined, a 20-bit watchdog SHALL:
- clear on RUN entry or i_alive=1;
- increment in RUN;
- on reaching WDOG_CYCLES-1 with i_alive=0, force HOLD next cycle and set o_wdog_trip=1, sticky until i_reset.
REQ-032 Without BOOT_WDOG_EN, no watchdog logic SHALL be built, o_wdog_trip SHALL be constant 0, and i_alive SHALL be ignored.

Verification
REQ-033 SHALL cover power-up: i_reset 1 for 3 cycles then 0, i_cfg_sw=8'h83, defaults -> o_core_reset_n rises on cycle 17 after release, o_cfg_sw=8'h83 from cycle 16, o_state sequence 00(x16),01,10.
REQ-034 SHALL cover CE rate: i_turbo=1 then 0 -> o_cpu_ce once every 2 cycles in RUN; after i_cfg_load, once every 4 cycles; a toggle of i_turbo mid-RUN leaves the rate unchanged.
REQ-035 SHALL cover re-latch: in RUN set i_cfg_sw=8'h05, pulse i_cfg_load -> o_core_reset_n=0 next cycle, o_cfg_sw=8'h05 after 16 HOLD cycles, release 1 cycle later.
REQ-036 SHALL cover watchdog with BOOT_WDOG_EN, WDOG_CYCLES=100:
- i_alive every 50 cycles -> no trip;
- i_alive stopped -> HOLD 100 cycles after the last kick, o_wdog_trip=1 until i_reset;
- without the macro -> o_wdog_trip stays 0.
REQ-037 SHALL cover simultaneous events and reset mid-operation:
- i_cfg_load on the expiry cycle -> single HOLD entry, o_wdog_trip=1;
- i_reset during LATCH -> next cycle o_state=00 and o_cfg_sw=8'h00.
